// File: rtl/vgg_pkg.sv
// vgg_pkg
// Items shared across the VGG16 datapath stages:
//   DATA_WIDTH     - pixel width (IEEE-754 single, sign at DATA_WIDTH-1)
//   feeder_state_e - state set of the relu_pool_feeder control FSM
//   ST_*           - the same states as plain logic [1:0] constants
//   relu()         - clamps any value with the sign bit set to +0.0
package vgg_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_STREAM = STREAM;
  localparam logic [1:0] ST_FLUSH  = FLUSH;
  localparam logic [1:0] ST_DONE   = DONE;

  // Only the sign bit is inspected: -0.0 and sign-set NaNs also become +0.0.
  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (v[DATA_WIDTH-1]) begin
      r = '0;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/relu_pool_feeder_if.sv
// relu_pool_feeder_if
// Stream bus between the convolution output, the feeder and the pooling block.
//   i_data/i_valid      - convolution result offered by upstream
//   o_ready             - feeder accepts; transfer = i_valid & o_ready
//   o_data/o_valid      - ReLU'd pixel towards pooling
//   o_win_valid(1)      - 2x2 window complete strobe and its one-cycle delay
//   o_frame_done        - end-of-flush pulse
// Modports: slave = feeder side, master = upstream/consumer side.
interface relu_pool_feeder_if #(
  parameter int DATA_WIDTH = vgg_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_win_valid;
  logic                  o_win_valid1;
  logic                  o_frame_done;

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_data, o_valid, o_win_valid, o_win_valid1, o_frame_done
  );

  modport master (
    output i_data, i_valid,
    input  o_ready, o_data, o_valid, o_win_valid, o_win_valid1, o_frame_done
  );
endinterface

// File: rtl/raster_counter.sv
// raster_counter
// Raster position tracker for a WIDTH x HEIGHT feature map.
//   clk, rst       - clock, asynchronous active-low reset
//   i_en           - advance one pixel (one accepted transfer)
//   o_col, o_row   - position of the pixel that the next enable consumes
//   o_last_pixel   - current position is the final pixel of the frame
//   o_win_done     - current position closes a 2x2 window (odd row, odd col)
module raster_counter #(
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6,
  parameter int CW     = $clog2(WIDTH),
  parameter int RW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last_pixel,
  output logic          o_win_done
);

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_last;
  logic          w_row_last;

  assign w_col_last = (r_col == COL_MAX);
  assign w_row_last = (r_row == ROW_MAX);

  // Column/row advance on each enabled pixel, wrapping at the frame edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_col        = r_col;
  assign o_row        = r_row;
  assign o_last_pixel = w_col_last & w_row_last;
  assign o_win_done   = r_col[0] & r_row[0];

endmodule

// File: rtl/relu_pool_feeder.sv
// relu_pool_feeder
// Applies ReLU to raster-ordered convolution results and produces the strobes
// the 2x2 max-pooling block needs. After each frame the input is stalled for
// FLUSH_CYCLES cycles plus one DONE cycle so the pooling pipeline drains.
//   clk, rst - clock, asynchronous active-low reset
//   io_bus   - relu_pool_feeder_if.slave (data in, ReLU data/strobes out)
module relu_pool_feeder
  import vgg_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int HEIGHT       = 6,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  relu_pool_feeder_if.slave   io_bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [FW-1:0]         r_flush_cnt;
  logic [FW-1:0]         w_flush_nxt;
  logic                  r_ready;
  logic                  r_frame_done;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_win_pend;
  logic                  r_win_valid;
  logic                  r_win_valid1;

  logic                  w_xfer;
  logic                  w_last_pixel;
  logic                  w_win_done;
  logic [CW-1:0]         w_col_unused;
  logic [RW-1:0]         w_row_unused;

  assign w_xfer = io_bus.i_valid & r_ready;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_xfer),
    .o_col        (w_col_unused),
    .o_row        (w_row_unused),
    .o_last_pixel (w_last_pixel),
    .o_win_done   (w_win_done)
  );

  // Frame control: stream until the last pixel, then drain and announce.
  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    case (r_state)
      ST_IDLE, ST_STREAM: begin
        if (w_xfer && w_last_pixel) begin
          w_state_nxt = ST_FLUSH;
          w_flush_nxt = FLUSH_LOAD;
        end else if (w_xfer) begin
          w_state_nxt = ST_STREAM;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_flush_nxt = r_flush_cnt - FW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, flush counter and the registered ready/frame-done outputs.
  // Ready is derived from the next state so it lines up with r_state; the
  // frame-done pulse is taken from DONE and so appears the cycle after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_flush_cnt  <= '0;
      r_ready      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_cnt  <= w_flush_nxt;
      r_ready      <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_STREAM);
      r_frame_done <= (r_state == ST_DONE);
    end
  end

  // ReLU output register and the window strobe pipeline: stage one mirrors
  // the line-buffer write, then win_valid and its delayed copy follow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_win_pend   <= 1'b0;
      r_win_valid  <= 1'b0;
      r_win_valid1 <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_data <= relu(io_bus.i_data);
      end
      r_valid      <= w_xfer;
      r_win_pend   <= w_xfer & w_win_done;
      r_win_valid  <= r_win_pend;
      r_win_valid1 <= r_win_valid;
    end
  end

  assign io_bus.o_ready      = r_ready;
  assign io_bus.o_data       = r_data;
  assign io_bus.o_valid      = r_valid;
  assign io_bus.o_win_valid  = r_win_valid;
  assign io_bus.o_win_valid1 = r_win_valid1;
  assign io_bus.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_relu_pool_feeder.sv
module tb_relu_pool_feeder;

  localparam int W    = 6;
  localparam int H    = 6;
  localparam int FL   = 3;
  localparam int NPIX = W * H;
  localparam int WB   = 4;
  localparam int HB   = 2;
  localparam int FLB  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  relu_pool_feeder_if bus ();
  relu_pool_feeder_if bus_b ();

  relu_pool_feeder #(.WIDTH(W), .HEIGHT(H), .FLUSH_CYCLES(FL)) dut (
    .clk(clk), .rst(rst), .io_bus(bus)
  );

  relu_pool_feeder #(.WIDTH(WB), .HEIGHT(HB), .FLUSH_CYCLES(FLB)) dut_b (
    .clk(clk), .rst(rst), .io_bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          t;
    logic [31:0] d;
  } exp_pix_t;

  exp_pix_t q_data[$];
  int       q_win[$];
  int       q_win1[$];
  int       q_done[$];
  int       pix_idx         = 0;
  int       ready_low_until = -1;
  int       ready_rise      = 1 << 30;
  bit       xfer_flag       = 1'b0;
  int       n_done_seen     = 0;

  bit          b_on = 1'b0;
  int          b_win[$];
  int          b_win1[$];
  int          b_done[$];
  logic [31:0] b_rx[$];
  int          b_ready_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Negative (sign set) clamps to +0.0, everything else passes unchanged.
  function automatic logic [31:0] ref_relu(input logic [31:0] v);
    return v[31] ? 32'h0000_0000 : v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and scoreboard for the 6x6 instance. cyc is the number of the
  // last rising edge; a transfer seen here happens at edge cyc+1.
  always @(negedge clk) begin : monitor
    exp_pix_t e;
    logic     ex;
    int       row;
    int       col;
    if (!rst) begin
      xfer_flag = 1'b0;
    end else begin
      ex = (q_data.size() > 0) && (q_data[0].t == cyc);
      check("o_valid", 32'(bus.o_valid), 32'(ex));
      if (ex) begin
        e = q_data.pop_front();
        if (bus.o_valid) check("o_data", bus.o_data, e.d);
      end
      ex = (q_win.size() > 0) && (q_win[0] == cyc);
      check("o_win_valid", 32'(bus.o_win_valid), 32'(ex));
      if (ex) void'(q_win.pop_front());
      ex = (q_win1.size() > 0) && (q_win1[0] == cyc);
      check("o_win_valid1", 32'(bus.o_win_valid1), 32'(ex));
      if (ex) void'(q_win1.pop_front());
      ex = (q_done.size() > 0) && (q_done[0] == cyc);
      check("o_frame_done", 32'(bus.o_frame_done), 32'(ex));
      if (ex) void'(q_done.pop_front());
      if (bus.o_frame_done) n_done_seen++;
      check("o_ready", 32'(bus.o_ready), 32'((cyc >= ready_rise) && (cyc > ready_low_until)));

      xfer_flag = bus.i_valid && bus.o_ready;
      if (xfer_flag) begin
        row = pix_idx / W;
        col = pix_idx % W;
        q_data.push_back('{cyc + 1, ref_relu(bus.i_data)});
        if ((row % 2 == 1) && (col % 2 == 1)) begin
          q_win.push_back(cyc + 2);
          q_win1.push_back(cyc + 3);
        end
        if (pix_idx == NPIX - 1) begin
          q_done.push_back(cyc + FL + 2);
          ready_low_until = cyc + 1 + FL;
          pix_idx = 0;
        end else begin
          pix_idx++;
        end
      end
    end
  end

  // Event recorder for the 4x2 instance.
  always @(negedge clk) begin
    if (b_on && rst) begin
      if (bus_b.o_valid)      b_rx.push_back(bus_b.o_data);
      if (bus_b.o_win_valid)  b_win.push_back(cyc);
      if (bus_b.o_win_valid1) b_win1.push_back(cyc);
      if (bus_b.o_frame_done) b_done.push_back(cyc);
      if (!bus_b.o_ready)     b_ready_low++;
    end
  end

  // Upstream driver: optional bubble, then hold the pixel until accepted.
  task automatic send(input logic [31:0] v, input int gap);
    int waited;
    if (gap > 0) begin
      bus.i_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    bus.i_valid = 1'b1;
    bus.i_data  = v;
    waited      = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!xfer_flag && waited < 40);
    if (!xfer_flag) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: pixel 0x%08h not taken in %0d cycles, required acceptance", v, waited);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required $finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] relu_vec [4];
    logic [31:0] b_in     [8];
    int          p0;
    relu_vec[0] = 32'h3F80_0000;
    relu_vec[1] = 32'hBF80_0000;
    relu_vec[2] = 32'h8000_0000;
    relu_vec[3] = 32'h7FC0_0000;
    bus.i_valid   = 1'b0;
    bus.i_data    = 32'h0;
    bus_b.i_valid = 1'b0;
    bus_b.i_data  = 32'h0;

    // Power-on reset state.
    #1 rst = 1'b0;
    #1;
    check("rst_o_data",   bus.o_data, 32'h0);
    check("rst_o_valid",  32'(bus.o_valid), 32'h0);
    check("rst_o_win",    32'(bus.o_win_valid), 32'h0);
    check("rst_o_win1",   32'(bus.o_win_valid1), 32'h0);
    check("rst_o_done",   32'(bus.o_frame_done), 32'h0);
    check("rst_o_ready",  32'(bus.o_ready), 32'h0);
    #21 rst = 1'b1;
    ready_rise = cyc + 1;
    @(posedge clk);
    #1;

    // Frame 1: directed ReLU values then random, no bubbles.
    for (int k = 0; k < NPIX; k++) send((k < 4) ? relu_vec[k] : $urandom, 0);
    // Frame 2: valid held across the flush, then random bubbles.
    for (int k = 0; k < NPIX; k++) send($urandom, (k == 0) ? 0 : int'($urandom_range(0, 2)));
    // Frame 3: partial, then reset mid-stream.
    for (int k = 0; k < 10; k++) send($urandom, 0);
    bus.i_valid = 1'b0;
    check("pre_rst_o_valid", 32'(bus.o_valid), 32'h1);
    check("pre_rst_o_win1",  32'(bus.o_win_valid1), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_o_data",  bus.o_data, 32'h0);
    check("mid_rst_o_valid", 32'(bus.o_valid), 32'h0);
    check("mid_rst_o_win",   32'(bus.o_win_valid), 32'h0);
    check("mid_rst_o_win1",  32'(bus.o_win_valid1), 32'h0);
    check("mid_rst_o_done",  32'(bus.o_frame_done), 32'h0);
    check("mid_rst_o_ready", 32'(bus.o_ready), 32'h0);
    q_data.delete();
    q_win.delete();
    q_win1.delete();
    q_done.delete();
    pix_idx         = 0;
    ready_low_until = -1;
    ready_rise      = 1 << 30;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    ready_rise = cyc + 1;
    @(posedge clk);
    #1;
    check("post_rst_col", 32'(dut.u_raster.o_col), 32'h0);
    check("post_rst_row", 32'(dut.u_raster.o_row), 32'h0);

    // Frame 4: fresh frame with random bubbles.
    for (int k = 0; k < NPIX; k++) send($urandom, int'($urandom_range(0, 3)));
    bus.i_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(q_data.size() + q_win.size() + q_win1.size() + q_done.size()), 32'h0);
    check("frame_done_count", 32'(n_done_seen), 32'd3);

    // Small geometry: 4x2 frame, one flush cycle, streamed continuously.
    for (int k = 0; k < 8; k++) b_in[k] = (k == 2) ? 32'hC000_0000 : 32'(k * 3 + 1);
    b_on = 1'b1;
    p0   = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      bus_b.i_valid = 1'b1;
      bus_b.i_data  = b_in[k];
      @(posedge clk);
      #1;
    end
    bus_b.i_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("b_valid_count", 32'(b_rx.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < b_rx.size()) check("b_data", b_rx[k], ref_relu(b_in[k]));
    check("b_win_count",  32'(b_win.size()), 32'd2);
    check("b_win0_time",  32'((b_win.size() > 0) ? b_win[0] - p0 : -1), 32'd6);
    check("b_win1_time",  32'((b_win.size() > 1) ? b_win[1] - p0 : -1), 32'd8);
    check("b_dly_count",  32'(b_win1.size()), 32'd2);
    check("b_dly0_time",  32'((b_win1.size() > 0) ? b_win1[0] - p0 : -1), 32'd7);
    check("b_dly1_time",  32'((b_win1.size() > 1) ? b_win1[1] - p0 : -1), 32'd9);
    check("b_done_count", 32'(b_done.size()), 32'd1);
    check("b_done_time",  32'((b_done.size() > 0) ? b_done[0] - p0 : -1), 32'd9);
    check("b_ready_low",  32'(b_ready_low), 32'(FLB + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
